alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU datapath between two requesters: port 0 is the pipeline execute stage, port 1 is an auxiliary client such as the CSR or debug unit.
- Each port has a valid/ready request channel (ALU control code plus two operands) and a valid/ready response channel (registered result).
- Round-robin arbitration grants at most one requester per cycle.
- Sits between the execute-stage operand muxes and the ALU.

Parameters:
- XLEN, 32, operand and result width.
- CTRL_W, 5, ALU control code width; matches the ALU_EXEC_* encodings.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req0_valid / i_req1_valid  in  1  request present.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle (grant).
- i_req0_ctrl / i_req1_ctrl  in  CTRL_W  ALU_EXEC_* code.
- i_req0_a, i_req0_b / i_req1_a, i_req1_b  in  XLEN  operands.
- o_rsp0_valid / o_rsp1_valid  out  1  result held.
- o_rsp0_result / o_rsp1_result  out  XLEN  registered ALU result.
- i_rsp0_ready / i_rsp1_ready  in  1  consumer takes the result.
- o_alu_ctrl  out  CTRL_W  to the ALU.
- o_alu_a / o_alu_b  out  XLEN  operands to the ALU.
- i_alu_result  in  XLEN  combinational ALU output.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_rspN_valid=0, o_rspN_result=0.
  - Priority pointer = port 0.
  - Optional counters = 0.
- Slot free for port N: slot_freeN = !o_rspN_valid || i_rspN_ready. This lets a response drain and refill in the same cycle.
- Eligibility: eligN = i_reqN_valid && slot_freeN.
- Grant (combinational):
  - Only one port eligible: that port wins.
  - Both eligible: the port named by the pointer wins.
  - Neither eligible: no grant.
- o_reqN_ready = grantN. o_reqN_ready must not depend on a port's own ready input; there is no combinational loop.
- ALU drive:
  - With a grant: o_alu_ctrl/a/b = the granted port's ctrl/a/b.
  - With no grant: all zero (ctrl 5'b00000), to reduce toggling.
- Latency: request accepted in cycle N; o_rspN_valid=1 with the result in cycle N+1. Throughput is one op per cycle across both ports.
- Response registers:
  - On grantN: o_rspN_result <= i_alu_result, o_rspN_valid <= 1.
  - Else if i_rspN_ready: o_rspN_valid <= 0, and o_rspN_result holds its last value.
  - Result stays stable while valid && !ready.
- Pointer update:
  - Changes only on a grant, to the other port: grant0 -> port 1 preferred next; grant1 -> port 0.
  - Unchanged when there is no grant.
- Boundary cases:
  - Both ports valid, port 0 slot full and not draining: port 1 granted regardless of the pointer.
  - Requester deasserts valid before a grant: legal, nothing recorded.
  - Response ready while not valid: ignored.
  - Reset mid-operation: the accepted-but-undelivered result is discarded and valid is cleared immediately (async).
- Control codes are passed through unchecked; decoding stays in the ALU.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- Defined:
  - Adds outputs o_perf_conflict (32 bit): counts cycles where both requests were valid and one lost. Saturates at all-ones.
  - Adds o_perf_stall (32 bit): counts cycles where a request was valid but its slot was not free. Saturates at all-ones.
  - Both counters are async-cleared by reset.
- Undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - ALU_EXEC_* codes and CTRL_W from types.vh.
  - Port index constants ALU_PORT_EXEC=0, ALU_PORT_AUX=1.
  - Perf counter width PERF_W=32.
- One sub-module, rr_arbiter2, contains:
  - Inputs: two eligibility bits, clock, reset, grant-accepted.
  - Outputs: one-hot grant.
  - The pointer flop.
  - It is reusable for other two-way shared resources.

Test Plan:
- Reset: hold i_rst_n=0 with both requests valid -> both o_reqN_ready=0 and both o_rspN_valid=0. After release, port 0 wins the first conflict.
- Single op: req0 ADD, a=5, b=7 -> o_req0_ready=1 in cycle 0; o_rsp0_valid=1, o_rsp0_result=12 in cycle 1; cleared the cycle after i_rsp0_ready=1.
- Conflict: both valid for 4 cycles with ready tied high, req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grants alternate 0,1,0,1; results 7 and 0xFF.
- Backpressure: i_rsp0_ready=0 with rsp0 held at 12 and a new req0 pending -> o_req0_ready=0, result stays 12. Concurrent req1 is granted every cycle.
- Drain-refill: rsp0 valid, i_rsp0_ready=1 and req0 valid in the same cycle -> grant0=1; the next cycle holds the new result with valid still 1.
- Async reset mid-flight: assert i_rst_n=0 between accept and delivery -> o_rsp0_valid drops before the next clock edge. With ALU_SHARE_ARB_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_share_arbiter_pkg - ALU control codes, port indices, shared helpers    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_share_arbiter_pkg;

  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_ADD    = 5'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_SUB    = 5'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_SLL    = 5'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_SLT    = 5'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_SLTU   = 5'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_XOR    = 5'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_SRL    = 5'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_SRA    = 5'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_OR     = 5'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_AND    = 5'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_EXEC_PASS_B = 5'd10;

  localparam int ALU_PORT_EXEC = 0;
  localparam int ALU_PORT_AUX  = 1;

  localparam int PERF_W = 32;

  typedef enum logic {
    PTR_EXEC = 1'b0,
    PTR_AUX  = 1'b1
  } rr_ptr_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    return (&value) ? value : value + PERF_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter2 - two-way round-robin arbiter with one-hot grant               |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2
  import alu_share_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       accept,
  output logic [1:0] grant
);

  rr_ptr_e ptr;
  rr_ptr_e ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_EXEC;
    end else begin
      ptr <= ptr_next;
    end
  end

  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == PTR_EXEC) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    // The winner yields priority to the other side on the next contest.
    if (accept && grant[ALU_PORT_EXEC]) begin
      ptr_next = PTR_AUX;
    end else if (accept && grant[ALU_PORT_AUX]) begin
      ptr_next = PTR_EXEC;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_share_arbiter - shares one ALU between execute and aux requesters;     |
// | ALU_SHARE_ARB_PERF_EN adds saturating conflict/stall counters. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [CTRL_W-1:0] i_req0_ctrl,
  input  logic [XLEN-1:0]   i_req0_a,
  input  logic [XLEN-1:0]   i_req0_b,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [CTRL_W-1:0] i_req1_ctrl,
  input  logic [XLEN-1:0]   i_req1_a,
  input  logic [XLEN-1:0]   i_req1_b,
  output logic              o_rsp0_valid,
  output logic [XLEN-1:0]   o_rsp0_result,
  input  logic              i_rsp0_ready,
  output logic              o_rsp1_valid,
  output logic [XLEN-1:0]   o_rsp1_result,
  input  logic              i_rsp1_ready,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic [XLEN-1:0]   o_alu_a,
  output logic [XLEN-1:0]   o_alu_b,
  input  logic [XLEN-1:0]   i_alu_result
`ifdef ALU_SHARE_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] o_perf_conflict,
  output logic [PERF_W-1:0] o_perf_stall
`endif
);

  logic       slot_free0;
  logic       slot_free1;
  logic [1:0] elig;
  logic [1:0] grant;

  // A held response that is being consumed this cycle frees its slot.
  assign slot_free0 = !o_rsp0_valid || i_rsp0_ready;
  assign slot_free1 = !o_rsp1_valid || i_rsp1_ready;

  // No grant is issued while reset is asserted, even with requests pending.
  assign elig[ALU_PORT_EXEC] = i_rst_n && i_req0_valid && slot_free0;
  assign elig[ALU_PORT_AUX]  = i_rst_n && i_req1_valid && slot_free1;

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .elig   (elig),
    .accept (1'b1),
    .grant  (grant)
  );

  assign o_req0_ready = grant[ALU_PORT_EXEC];
  assign o_req1_ready = grant[ALU_PORT_AUX];

  always_comb begin
    o_alu_ctrl = '0;
    o_alu_a    = '0;
    o_alu_b    = '0;
    if (grant[ALU_PORT_EXEC]) begin
      o_alu_ctrl = i_req0_ctrl;
      o_alu_a    = i_req0_a;
      o_alu_b    = i_req0_b;
    end else if (grant[ALU_PORT_AUX]) begin
      o_alu_ctrl = i_req1_ctrl;
      o_alu_a    = i_req1_a;
      o_alu_b    = i_req1_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp0_valid  <= 1'b0;
      o_rsp0_result <= '0;
    end else if (grant[ALU_PORT_EXEC]) begin
      o_rsp0_valid  <= 1'b1;
      o_rsp0_result <= i_alu_result;
    end else if (i_rsp0_ready) begin
      o_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp1_valid  <= 1'b0;
      o_rsp1_result <= '0;
    end else if (grant[ALU_PORT_AUX]) begin
      o_rsp1_valid  <= 1'b1;
      o_rsp1_result <= i_alu_result;
    end else if (i_rsp1_ready) begin
      o_rsp1_valid  <= 1'b0;
    end
  end

`ifdef ALU_SHARE_ARB_PERF_EN
  logic conflict_hit;
  logic stall_hit;

  // A conflict is a cycle where both asked and exactly one was served.
  assign conflict_hit = i_req0_valid && i_req1_valid && (grant != 2'b00);
  assign stall_hit    = (i_req0_valid && !slot_free0) || (i_req1_valid && !slot_free1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_conflict <= '0;
      o_perf_stall    <= '0;
    end else begin
      if (conflict_hit) begin
        o_perf_conflict <= sat_inc(o_perf_conflict);
      end
      if (stall_hit) begin
        o_perf_stall <= sat_inc(o_perf_stall);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_share_arbiter - directed self-checking bench for alu_share_arbiter  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
`ifdef ALU_SHARE_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_stall;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req0_valid  (req0_valid),
    .o_req0_ready  (req0_ready),
    .i_req0_ctrl   (req0_ctrl),
    .i_req0_a      (req0_a),
    .i_req0_b      (req0_b),
    .i_req1_valid  (req1_valid),
    .o_req1_ready  (req1_ready),
    .i_req1_ctrl   (req1_ctrl),
    .i_req1_a      (req1_a),
    .i_req1_b      (req1_b),
    .o_rsp0_valid  (rsp0_valid),
    .o_rsp0_result (rsp0_result),
    .i_rsp0_ready  (rsp0_ready),
    .o_rsp1_valid  (rsp1_valid),
    .o_rsp1_result (rsp1_result),
    .i_rsp1_ready  (rsp1_ready),
    .o_alu_ctrl    (alu_ctrl),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .i_alu_result  (alu_result)
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    .o_perf_conflict (perf_conflict),
    .o_perf_stall    (perf_stall)
`endif
  );

  // Stand-in for the shared ALU.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_EXEC_ADD: alu_result = alu_a + alu_b;
      ALU_EXEC_SUB: alu_result = alu_a - alu_b;
      ALU_EXEC_XOR: alu_result = alu_a ^ alu_b;
      default:      alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both requesters asking.
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_EXEC_ADD; req0_a = 32'd5;    req0_b = 32'd7;
    req1_valid = 1'b1; req1_ctrl = ALU_EXEC_XOR; req1_a = 32'hF0;   req1_b = 32'h0F;
    cyc();
    cyc();
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    check("rst_rsp1_result", rsp1_result, 32'd0);
    check("rst_alu_a_idle", alu_a, 32'd0);

    // Release: port 0 wins the first conflict; single ADD 5+7.
    rst_n = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    #1;
    check("first_ready0", 32'(req0_ready), 32'd1);
    check("first_ready1", 32'(req1_ready), 32'd0);
    check("first_alu_ctrl", 32'(alu_ctrl), 32'(ALU_EXEC_ADD));
    check("first_alu_a", alu_a, 32'd5);
    check("first_alu_b", alu_b, 32'd7);
    cyc();
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    #1;
    check("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("single_rsp0_result", rsp0_result, 32'd12);
    check("single_ready1", 32'(req1_ready), 32'd1);
    cyc();
    check("single_rsp0_cleared", 32'(rsp0_valid), 32'd0);
    check("single_rsp0_hold", rsp0_result, 32'd12);
    check("single_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("single_rsp1_result", rsp1_result, 32'h000000FF);

    // Conflict: both valid every cycle, grants alternate starting with port 0.
    req0_valid = 1'b1; req0_ctrl = ALU_EXEC_SUB; req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("conf_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("conf_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 1) begin
        check("conf_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("conf_rsp0_result", rsp0_result, 32'd7);
      end
      cyc();
    end
    check("conf_end_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("conf_end_rsp1_result", rsp1_result, 32'h000000FF);
    check("conf_end_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("conf_end_rsp0_result", rsp0_result, 32'd7);

    // Backpressure: rsp0 held at 12, port 1 served every cycle regardless of pointer.
    req1_valid = 1'b0; rsp0_ready = 1'b0;
    req0_ctrl = ALU_EXEC_ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    check("bp_load_ready0", 32'(req0_ready), 32'd1);
    cyc();
    req0_a = 32'd1; req0_b = 32'd1; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd1);
      check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("bp_rsp0_result", rsp0_result, 32'd12);
      cyc();
    end

    // Drain-refill in one cycle.
    rsp0_ready = 1'b1;
    #1;
    check("dr_ready0", 32'(req0_ready), 32'd1);
    check("dr_ready1", 32'(req1_ready), 32'd0);
    cyc();
    req1_valid = 1'b0; req0_a = 32'd20; req0_b = 32'd22;
    #1;
    check("dr_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("dr_rsp0_result", rsp0_result, 32'd2);
    check("dr_ready0_again", 32'(req0_ready), 32'd1);
    cyc();

    // Async reset while a result is held: cleared without a clock edge.
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    #1;
    check("ar_rsp0_result_pre", rsp0_result, 32'd42);
    check("ar_rsp0_valid_pre", 32'(rsp0_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("ar_rsp0_result", rsp0_result, 32'd0);
`ifdef ALU_SHARE_ARB_PERF_EN
    check("ar_perf_conflict", perf_conflict, 32'd0);
    check("ar_perf_stall", perf_stall, 32'd0);
`endif
    cyc();
    cyc();

    // After reset the pointer favours port 0 again.
    rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
